// File: rtl/tl_pkg.sv
// TileLink-UL opcode enums and beat arithmetic shared by the ROM path blocks.
package tl_pkg;

    typedef enum logic [2:0] {
        PUT_FULL_DATA    = 3'd0,
        PUT_PARTIAL_DATA = 3'd1,
        ARITHMETIC_DATA  = 3'd2,
        LOGICAL_DATA     = 3'd3,
        GET              = 3'd4,
        INTENT           = 3'd5
    } tl_a_op_e;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1
    } tl_d_op_e;

    localparam int unsigned BEAT_CNT_W = 8;

    // Beats-1 for a transfer of 2^size bytes on a bus of 2^beat_log2 bytes.
    function automatic logic [BEAT_CNT_W-1:0] tl_beats_m1(input int unsigned size,
                                                          input int unsigned beat_log2);
        if (size <= beat_log2) return '0;
        return BEAT_CNT_W'((32'd1 << (size - beat_log2)) - 32'd1);
    endfunction

endpackage

// File: rtl/tl_rom_beat_counter.sv
// Beat counter for TileLink bursts: index counts up from 0, last flags the final beat.
// Latency: index/last reflect a load or step from the following cycle.
// Backpressure: advances only on step; holds at the final beat once last is set.
module tl_rom_beat_counter
    import tl_pkg::*;
#(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned SizeWidth = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load,
    input  logic [SizeWidth-1:0]  size,
    input  logic                  step,
    output logic [BEAT_CNT_W-1:0] index,
    output logic                  last
);

    localparam int unsigned BeatLog2 = $clog2(DataWidth / 8);

    logic [BEAT_CNT_W-1:0] remain_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            remain_q <= '0;
            index    <= '0;
        end else if (load) begin
            remain_q <= tl_beats_m1(32'(size), BeatLog2);
            index    <= '0;
        end else if (step && !last) begin
            remain_q <= remain_q - BEAT_CNT_W'(1);
            index    <= index + BEAT_CNT_W'(1);
        end
    end

    assign last = (remain_q == '0);

endmodule

// File: rtl/tl_rom_device.sv
// TL-UL responder for a synchronous ROM; Get -> AccessAckData bursts, all else -> denied AccessAck.
// Latency: first D beat 2 cycles after A accept, then 1 beat per 2 cycles; optional TL_ROM_DEVICE_ADDR_CHECK_EN.
// Backpressure: one transaction in flight; D fields held while host_d_ready is low, A stalled outside IDLE/DRAIN.
module tl_rom_device
    import tl_pkg::*;
#(
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned AddrWidth   = 56,
    parameter int unsigned SourceWidth = 1,
    parameter int unsigned SinkWidth   = 1,
    parameter int unsigned MaxSize     = 6,
    parameter int unsigned RomDepth    = 512,
    parameter int unsigned SizeWidth   = $clog2(MaxSize + 1),
    parameter int unsigned RomAddrW    = $clog2(RomDepth)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   host_a_valid,
    output logic                   host_a_ready,
    input  logic [2:0]             host_a_opcode,
    input  logic [2:0]             host_a_param,
    input  logic [SizeWidth-1:0]   host_a_size,
    input  logic [SourceWidth-1:0] host_a_source,
    input  logic [AddrWidth-1:0]   host_a_address,
    input  logic [DataWidth/8-1:0] host_a_mask,
    input  logic                   host_a_corrupt,
    input  logic [DataWidth-1:0]   host_a_data,
    output logic                   host_d_valid,
    input  logic                   host_d_ready,
    output logic [2:0]             host_d_opcode,
    output logic [2:0]             host_d_param,
    output logic [SizeWidth-1:0]   host_d_size,
    output logic [SourceWidth-1:0] host_d_source,
    output logic [SinkWidth-1:0]   host_d_sink,
    output logic                   host_d_denied,
    output logic                   host_d_corrupt,
    output logic [DataWidth-1:0]   host_d_data,
    output logic                   rom_req_o,
    output logic [RomAddrW-1:0]    rom_addr_o,
    input  logic [DataWidth-1:0]   rom_data_i
);

    localparam int unsigned BeatLog2 = $clog2(DataWidth / 8);
`ifdef TL_ROM_DEVICE_ADDR_CHECK_EN
    localparam int unsigned WordW = AddrWidth - BeatLog2;
`else
    localparam int unsigned WordW = RomAddrW;
`endif

    typedef enum logic [2:0] {IDLE, READ, RESP, DRAIN, ERR} state_e;

    state_e                  state_q, state_d;
    logic [SizeWidth-1:0]    size_q;
    logic [SourceWidth-1:0]  src_q;
    logic [WordW-1:0]        word_q;
    logic [WordW-1:0]        word_idx;
    logic [DataWidth-1:0]    data_q;
    logic                    alive_q, resp_first_q, oob_q, beat_oob;
    logic [BEAT_CNT_W-1:0]   beat_idx;
    logic                    beat_last, a_fire, d_fire, multi_beat, is_put;
    logic                    unused_sig;

    assign a_fire     = host_a_valid && host_a_ready;
    assign d_fire     = host_d_valid && host_d_ready;
    assign multi_beat = (tl_beats_m1(32'(host_a_size), BeatLog2) != '0);
    assign is_put     = (host_a_opcode == PUT_FULL_DATA) || (host_a_opcode == PUT_PARTIAL_DATA);
    assign word_idx   = word_q + WordW'(beat_idx);
    assign rom_addr_o = word_idx[RomAddrW-1:0];

`ifdef TL_ROM_DEVICE_ADDR_CHECK_EN
    assign beat_oob = (word_idx >= WordW'(RomDepth));
`else
    assign beat_oob = 1'b0;
`endif

    tl_rom_beat_counter #(
        .DataWidth (DataWidth),
        .SizeWidth (SizeWidth)
    ) u_beat_counter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load   (a_fire && (state_q == IDLE)),
        .size   (host_a_size),
        .step   ((state_q == RESP && d_fire) || (state_q == DRAIN && a_fire)),
        .index  (beat_idx),
        .last   (beat_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            alive_q      <= 1'b0;
            size_q       <= '0;
            src_q        <= '0;
            word_q       <= '0;
            data_q       <= '0;
            resp_first_q <= 1'b0;
            oob_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            alive_q      <= 1'b1;
            resp_first_q <= (state_q == READ);
            if (a_fire && state_q == IDLE) begin
                size_q <= host_a_size;
                src_q  <= host_a_source;
                word_q <= host_a_address[BeatLog2 +: WordW];
            end
            if (state_q == READ) oob_q <= beat_oob;
            // ROM data is only valid the cycle after the strobe; keep it for stalls.
            if (resp_first_q) data_q <= rom_data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (a_fire) begin
                if (host_a_opcode == GET)      state_d = READ;
                else if (is_put && multi_beat) state_d = DRAIN;
                else                           state_d = ERR;
            end
            READ:  state_d = RESP;
            RESP:  if (d_fire) state_d = beat_last ? IDLE : READ;
            DRAIN: if (beat_last) state_d = ERR;
            ERR:   if (d_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        host_a_ready   = 1'b0;
        host_d_valid   = 1'b0;
        host_d_opcode  = ACCESS_ACK;
        host_d_denied  = 1'b0;
        host_d_corrupt = 1'b0;
        host_d_data    = '0;
        rom_req_o      = 1'b0;
        case (state_q)
            IDLE:  host_a_ready = alive_q;
            READ:  rom_req_o = !beat_oob;
            RESP: begin
                host_d_valid   = 1'b1;
                host_d_opcode  = ACCESS_ACK_DATA;
                host_d_denied  = oob_q;
                host_d_corrupt = oob_q;
                if (!oob_q) host_d_data = resp_first_q ? rom_data_i : data_q;
            end
            // The final Put beat was taken once last is set; stop accepting.
            DRAIN: host_a_ready = !beat_last;
            ERR: begin
                host_d_valid  = 1'b1;
                host_d_denied = 1'b1;
            end
            default: ;
        endcase
    end

    assign host_d_param  = '0;
    assign host_d_size   = size_q;
    assign host_d_source = src_q;
    assign host_d_sink   = '0;
    assign unused_sig    = ^{host_a_param, host_a_mask, host_a_corrupt, host_a_data, host_a_address};

endmodule
